photoswitch_sequencer: RTL and testbench
========================================

# photoswitch_sequencer

Sequences set/reset drive pulses for one photonic switch and arbitrates between a set requester and a reset requester that share the PWMset/PWMreset drive pair. Pulse widths and the mandatory dead time are counted in enable ticks (e.g. the 1 MHz enable), not in core clocks. The block sits between the control logic that decides switch state and the switch driver outputs.

## Interface
- `WIDTH`, 7: bit width of the pulse-width inputs and the tick counter.
- `DEAD_TICKS`, 24: dead-time length in enable ticks after every pulse; legal range 1..2^WIDTH-1.
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `en` in 1: tick enable; the tick counter decrements only in cycles where `en`=1.
- `req_set` in 1: level request for a set pulse; held until `ack_set`.
- `req_reset` in 1: level request for a reset pulse; held until `ack_reset`.
- `set_width` in WIDTH: set pulse width in ticks; sampled at grant.
- `reset_width` in WIDTH: reset pulse width in ticks; sampled at grant.
- `PWMset` out 1: set drive pulse, registered.
- `PWMreset` out 1: reset drive pulse, registered.
- `ack_set` out 1: one-cycle completion strobe for a set request.
- `ack_reset` out 1: one-cycle completion strobe for a reset request.
- `busy` out 1: high in every state except IDLE.
- `switch_state` out 1: 1 after a completed nonzero set, 0 after a completed nonzero reset.

## Operation
- States: IDLE, PULSE, DEAD. Registers: state, `cnt`[WIDTH-1:0], `sel` (0=set, 1=reset), `prio`, all outputs.
- Reset values: state=IDLE, `cnt`=0, `sel`=0, `prio`=0 (favours set), every output 0.
- IDLE: arbitration runs every cycle, independent of `en`. If only one request is high, it wins. If both are high, `prio` decides: 0 selects set, 1 selects reset. The winner is latched into `sel` and its width into `cnt`.
  - Nonzero width: go to PULSE. The matching PWM output goes high on the same edge.
  - Zero width: no pulse and no dead time. Stay in IDLE and assert the matching ack on the next edge. `switch_state` is unchanged.
- PULSE: when `en`=1 and `cnt`>1, decrement `cnt`. When `en`=1 and `cnt`=1, drop the PWM output, load `cnt`=DEAD_TICKS, and go to DEAD.
- DEAD: both PWM outputs are low. `cnt` counts down the same way. When `en`=1 and `cnt`=1, return to IDLE and, on that edge:
  - assert the matching ack for exactly one cycle;
  - update `switch_state` (`sel`=0 sets it to 1, `sel`=1 clears it to 0);
  - set `prio` to the non-served requester.
- A zero-width grant also toggles `prio` to the non-served requester.
- Handshake: the requester drops its req in the cycle after seeing ack. A req still high in the cycle after ack is treated as a new request. Requests arriving during PULSE or DEAD wait; they are never dropped.
- Invariant: `PWMset` and `PWMreset` are never high together, and only one of `ack_set`/`ack_reset` is high in any cycle.
- Width inputs may change freely after grant; the latched `cnt` governs.

## Timing
- Grant to PWM rise: 1 clk (registered).
- With `en`=1 every cycle, width W, request seen in IDLE at cycle 0:
  - PWM high cycles 1..W;
  - dead time cycles W+1..W+DEAD_TICKS;
  - ack in cycle W+DEAD_TICKS+1.
- Zero width: ack in cycle 1.
- `en` low stretches PULSE/DEAD. Outputs and `cnt` hold. Pulse length in ticks is exact regardless of `en` duty.
- Back-to-back: the earliest next grant is the cycle after ack; the next PWM rise comes 1 clk after that grant.
- Reset mid-PULSE or mid-DEAD: both PWM outputs fall asynchronously. No ack is issued and any pending request is lost until re-asserted after reset falls. `switch_state` returns to 0.

## Test plan
- `req_set`, `set_width`=3, DEAD_TICKS=24, `en`=1 constantly: `PWMset` high cycles 1-3, ack in cycle 28, `switch_state`=1, `PWMreset` never high.
- `req_set` and `req_reset` both high from reset, widths 79/80: set served first (PWMset high for 79 cycles), then reset (PWMreset high for 80 cycles, following the dead time and the ack cycle), with no overlap. Final `switch_state`=0.
- `en` pulsing 1-of-8 cycles, `reset_width`=2: `PWMreset` spans exactly 2 enable ticks, dead time spans 24 ticks, and ack is a single clk wide.
- `set_width`=0 request: no PWM activity, `ack_set` in cycle 1, `busy` stays 0, `switch_state` unchanged.
- `reset` asserted at mid-pulse cycle 40 of a width-79 set: `PWMset` drops immediately, all outputs stay 0 through reset, no ack. A re-issued request after reset falls completes normally.
- `req_set` held high through ack: a second full set sequence starts in the cycle after ack.

Source files
------------

// File: rtl/photoswitch_sequencer.sv
// Set/reset pulse sequencer for one photonic switch: arbitrates two requesters,
// times the drive pulse and the following dead time in enable ticks.
module photoswitch_sequencer #(
  parameter int WIDTH      = 7,
  parameter int DEAD_TICKS = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req_set,
  input  logic             req_reset,
  input  logic [WIDTH-1:0] set_width,
  input  logic [WIDTH-1:0] reset_width,
  output logic             PWMset,
  output logic             PWMreset,
  output logic             ack_set,
  output logic             ack_reset,
  output logic             busy,
  output logic             switch_state,
  output logic [1:0]       dbg_state
);

  // Handshake: req_* is a level held until the matching one-cycle ack_*;
  // the requester drops req the cycle after ack. No grant is made in the ack
  // cycle, so a req still high one cycle after ack is a fresh request.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEAD_LOAD = WIDTH'(DEAD_TICKS);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_sel;
  logic             r_prio;
  logic             r_pwm_set;
  logic             r_pwm_reset;
  logic             r_ack_set;
  logic             r_ack_reset;
  logic             r_busy;
  logic             r_switch_state;

  logic             w_ack_any;
  logic             w_req_any;
  logic             w_pick_reset;
  logic [WIDTH-1:0] w_width;
  logic             w_width_zero;

  assign w_ack_any    = r_ack_set | r_ack_reset;
  assign w_req_any    = (req_set | req_reset) & ~w_ack_any;
  assign w_pick_reset = req_reset & (~req_set | r_prio);
  assign w_width      = w_pick_reset ? reset_width : set_width;
  assign w_width_zero = (w_width == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_sel          <= 1'b0;
      r_prio         <= 1'b0;
      r_pwm_set      <= 1'b0;
      r_pwm_reset    <= 1'b0;
      r_ack_set      <= 1'b0;
      r_ack_reset    <= 1'b0;
      r_busy         <= 1'b0;
      r_switch_state <= 1'b0;
    end else begin
      r_ack_set   <= 1'b0;
      r_ack_reset <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_sel <= w_pick_reset;
            r_cnt <= w_width;
            if (!w_width_zero) begin
              r_state     <= S_PULSE;
              r_busy      <= 1'b1;
              r_pwm_set   <= ~w_pick_reset;
              r_pwm_reset <= w_pick_reset;
            end else begin
              // Zero width completes at once: ack only, no drive, no dead time.
              r_ack_set   <= ~w_pick_reset;
              r_ack_reset <= w_pick_reset;
              r_prio      <= ~w_pick_reset;
            end
          end
        end
        S_PULSE: begin
          if (en) begin
            if (r_cnt > CNT_ONE) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else begin
              r_pwm_set   <= 1'b0;
              r_pwm_reset <= 1'b0;
              r_cnt       <= DEAD_LOAD;
              r_state     <= S_DEAD;
            end
          end
        end
        S_DEAD: begin
          if (en) begin
            if (r_cnt > CNT_ONE) begin
              r_cnt <= r_cnt - CNT_ONE;
            end else begin
              r_state        <= S_IDLE;
              r_busy         <= 1'b0;
              r_ack_set      <= ~r_sel;
              r_ack_reset    <= r_sel;
              r_switch_state <= ~r_sel;
              r_prio         <= ~r_sel;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_pwm_set   <= 1'b0;
          r_pwm_reset <= 1'b0;
        end
      endcase
    end
  end

  assign PWMset       = r_pwm_set;
  assign PWMreset     = r_pwm_reset;
  assign ack_set      = r_ack_set;
  assign ack_reset    = r_ack_reset;
  assign busy         = r_busy;
  assign switch_state = r_switch_state;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_photoswitch_sequencer.sv
// Directed bench for photoswitch_sequencer: cycle-by-cycle expected waveforms
// derived by hand from the pulse/dead/ack timing (WIDTH=7, DEAD_TICKS=24).
module tb_photoswitch_sequencer;

  localparam int WIDTH = 7;
  localparam int DEAD  = 24;

  logic             clk;
  logic             reset;
  logic             en;
  logic             req_set;
  logic             req_reset;
  logic [WIDTH-1:0] set_width;
  logic [WIDTH-1:0] reset_width;
  logic             PWMset;
  logic             PWMreset;
  logic             ack_set;
  logic             ack_reset;
  logic             busy;
  logic             switch_state;
  logic [1:0]       dbg_state;

  int n_cmp;
  int n_fail;

  photoswitch_sequencer #(.WIDTH(WIDTH), .DEAD_TICKS(DEAD)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .req_set      (req_set),
    .req_reset    (req_reset),
    .set_width    (set_width),
    .reset_width  (reset_width),
    .PWMset       (PWMset),
    .PWMreset     (PWMreset),
    .ack_set      (ack_set),
    .ack_reset    (ack_reset),
    .busy         (busy),
    .switch_state (switch_state),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_cyc(input string tag, input int c, input logic e_ps, input logic e_pr,
                         input logic e_as, input logic e_ar, input logic e_busy);
    chk($sformatf("%s c%0d PWMset", tag, c), 32'(PWMset), 32'(e_ps));
    chk($sformatf("%s c%0d PWMreset", tag, c), 32'(PWMreset), 32'(e_pr));
    chk($sformatf("%s c%0d ack_set", tag, c), 32'(ack_set), 32'(e_as));
    chk($sformatf("%s c%0d ack_reset", tag, c), 32'(ack_reset), 32'(e_ar));
    chk($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(e_busy));
    chk($sformatf("%s c%0d pwm_excl", tag, c), 32'(PWMset & PWMreset), 32'd0);
    chk($sformatf("%s c%0d ack_excl", tag, c), 32'(ack_set & ack_reset), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk_cyc(tag, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, " switch_state"}, 32'(switch_state), 32'd0);
    chk({tag, " dbg_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk_quiet("reset");
    reset = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    en          = 1'b1;
    req_set     = 1'b0;
    req_reset   = 1'b0;
    set_width   = '0;
    reset_width = '0;
    do_reset();

    // T1: set width 3, en always high -> PWM 1..3, ack at 28
    set_width = 7'd3;
    req_set   = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      chk_cyc("t1", c, (c >= 1 && c <= 3), 1'b0, (c == 28), 1'b0, (c >= 1 && c <= 27));
      if (c == 28) begin
        chk("t1 switch_state", 32'(switch_state), 32'd1);
        req_set = 1'b0;
      end
    end

    // T4: zero-width set -> ack at cycle 1, no drive, switch_state stays 1
    set_width = 7'd0;
    req_set   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk_cyc("t4", c, 1'b0, 1'b0, (c == 1), 1'b0, 1'b0);
      chk($sformatf("t4 c%0d switch_state", c), 32'(switch_state), 32'd1);
      if (c == 1) req_set = 1'b0;
    end

    // T2: both requests from reset, widths 79/80: set first, then reset
    set_width   = 7'd79;
    reset_width = 7'd80;
    req_set     = 1'b1;
    req_reset   = 1'b1;
    do_reset();
    for (int c = 1; c <= 212; c++) begin
      step();
      chk_cyc("t2", c, (c >= 1 && c <= 79), (c >= 106 && c <= 185), (c == 104), (c == 210),
              (c <= 103) || (c >= 106 && c <= 209));
      if (c == 104) begin
        chk("t2 switch_state set", 32'(switch_state), 32'd1);
        req_set = 1'b0;
      end
      if (c == 210) begin
        chk("t2 switch_state reset", 32'(switch_state), 32'd0);
        req_reset = 1'b0;
      end
    end

    // T3: en high 1-of-8 cycles (cycles 8,16,...), reset width 2
    reset_width = 7'd2;
    req_reset   = 1'b1;
    en          = 1'b0;
    for (int c = 1; c <= 212; c++) begin
      step();
      chk_cyc("t3", c, 1'b0, (c >= 1 && c <= 16), 1'b0, (c == 209), (c >= 1 && c <= 208));
      if (c == 209) req_reset = 1'b0;
      en = ((c % 8) == 0);
    end
    en = 1'b1;

    // T5: reset at cycle 40 of a width-79 set, then a re-issued width-5 set
    set_width = 7'd79;
    req_set   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      chk_cyc("t5", c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    reset = 1'b1;
    #1;
    chk("t5 async PWMset", 32'(PWMset), 32'd0);
    chk("t5 async busy", 32'(busy), 32'd0);
    req_set = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_quiet("t5 in_reset");
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk_quiet("t5 post_reset");
    end
    set_width = 7'd5;
    req_set   = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      chk_cyc("t5b", c, (c >= 1 && c <= 5), 1'b0, (c == 30), 1'b0, (c >= 1 && c <= 29));
      if (c == 30) begin
        chk("t5b switch_state", 32'(switch_state), 32'd1);
        req_set = 1'b0;
      end
    end

    // T6: req_set held through ack -> second sequence granted the cycle after ack
    set_width = 7'd2;
    req_set   = 1'b1;
    for (int c = 1; c <= 57; c++) begin
      step();
      chk_cyc("t6", c, (c >= 1 && c <= 2) || (c >= 29 && c <= 30), 1'b0,
              (c == 27) || (c == 55), 1'b0, (c >= 1 && c <= 26) || (c >= 29 && c <= 54));
      if (c == 55) req_set = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
